// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Channel count, select width and the routing-mode encoding live here.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load and a drain can land on the same edge, so the channel sustains one beat per cycle.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain_ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // A load wins over a drain, so a simultaneous drain and load keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && drain_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/demux1to4_stream.sv
// Valid/ready 1-to-4 stream demultiplexer with explicit or round-robin routing.
// The top keeps only the destination decode, the upstream ready and the round-robin pointer.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_valid,
    input  logic [W-1:0]        in_data,
    output logic                in_ready,
    output logic [NUM_CH-1:0]   out_valid,
    output logic [NUM_CH*W-1:0] out_data,
    input  logic [NUM_CH-1:0]   out_ready,
    output logic [SEL_W-1:0]    rr_ptr
);

    logic [SEL_W-1:0]  dst;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [SEL_W-1:0]  rr_ptr_reg;
    logic [SEL_W-1:0]  rr_ptr_next;

    always_comb begin
        dst = (mode == MODE_RR) ? rr_ptr_reg : in_sel;
    end

    // Ready depends only on the destination slot, never on in_valid.
    assign in_ready = ~out_valid[dst] | out_ready[dst];
    assign accept   = in_valid & in_ready;

    // The pointer waits on a full, non-draining slot rather than skipping ahead.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept && (mode == MODE_RR)) begin
            rr_ptr_next = rr_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign rr_ptr = rr_ptr_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign load[gi] = accept && (dst == SEL_W'(gi));

            demux_slot #(
                .W (W)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .load        (load[gi]),
                .load_data   (in_data),
                .drain_ready (out_ready[gi]),
                .valid       (out_valid[gi]),
                .data        (out_data[gi*W +: W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed, table-driven bench for demux1to4_stream with hand-written reset sequences.
module tb_demux1to4_stream;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;

    int passed;
    int total;

    typedef struct {
        logic        m;
        logic [1:0]  sel;
        logic        iv;
        logic [7:0]  d;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  ov;
        logic [31:0] od;
        logic [1:0]  rr;
    } vec_t;

    vec_t vecs[23];

    demux1to4_stream #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic m, logic [1:0] sel, logic iv, logic [7:0] d,
                                logic [3:0] ordy, logic rdy, logic [3:0] ov,
                                logic [31:0] od, logic [1:0] rr);
        vec_t v;
        v.m = m; v.sel = sel; v.iv = iv; v.d = d; v.ordy = ordy;
        v.rdy = rdy; v.ov = ov; v.od = od; v.rr = rr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [1:0] sel, input logic iv,
                         input logic [7:0] d, input logic [3:0] ordy);
        mode = m; in_sel = sel; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        rst_n = 1'b1;

        // Row layout: mode sel valid data out_ready | in_ready out_valid out_data rr_ptr
        vecs[0]  = mk(0, 2, 1, 8'hA5, 4'hF, 1, 4'b0100, 32'h00A50000, 0);
        vecs[1]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h00A50000, 0);
        vecs[2]  = mk(0, 1, 1, 8'h11, 4'hD, 1, 4'b0010, 32'h00A51100, 0);
        vecs[3]  = mk(0, 1, 1, 8'h22, 4'hD, 0, 4'b0010, 32'h00A51100, 0);
        vecs[4]  = mk(0, 1, 1, 8'h22, 4'hF, 1, 4'b0010, 32'h00A52200, 0);
        vecs[5]  = mk(0, 1, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h00A52200, 0);
        vecs[6]  = mk(0, 3, 1, 8'h33, 4'hF, 1, 4'b1000, 32'h33A52200, 0);
        vecs[7]  = mk(0, 3, 1, 8'h44, 4'hF, 1, 4'b1000, 32'h44A52200, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h44A52200, 0);
        vecs[9]  = mk(1, 3, 1, 8'h00, 4'hF, 1, 4'b0001, 32'h44A52200, 1);
        vecs[10] = mk(1, 3, 1, 8'h01, 4'hF, 1, 4'b0010, 32'h44A50100, 2);
        vecs[11] = mk(1, 0, 1, 8'h02, 4'hF, 1, 4'b0100, 32'h44020100, 3);
        vecs[12] = mk(1, 0, 1, 8'h03, 4'hF, 1, 4'b1000, 32'h03020100, 0);
        vecs[13] = mk(1, 2, 1, 8'h04, 4'hF, 1, 4'b0001, 32'h03020104, 1);
        vecs[14] = mk(1, 2, 1, 8'h05, 4'hF, 1, 4'b0010, 32'h03020504, 2);
        vecs[15] = mk(0, 0, 1, 8'h66, 4'hF, 1, 4'b0001, 32'h03020566, 2);
        vecs[16] = mk(1, 0, 1, 8'h07, 4'hF, 1, 4'b0100, 32'h03070566, 3);
        vecs[17] = mk(1, 0, 1, 8'h08, 4'hF, 1, 4'b1000, 32'h08070566, 0);
        vecs[18] = mk(1, 0, 1, 8'h09, 4'hD, 1, 4'b0001, 32'h08070509, 1);
        vecs[19] = mk(0, 1, 1, 8'h0A, 4'hD, 1, 4'b0010, 32'h08070A09, 1);
        vecs[20] = mk(1, 0, 1, 8'h0B, 4'hD, 0, 4'b0010, 32'h08070A09, 1);
        vecs[21] = mk(1, 0, 1, 8'h0B, 4'hF, 1, 4'b0010, 32'h08070B09, 2);
        vecs[22] = mk(1, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'h08070B09, 2);

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_rr_ptr", {30'd0, rr_ptr}, 32'h0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].m, vecs[i].sel, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].ov});
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d_rr_ptr", i), {30'd0, rr_ptr}, {30'd0, vecs[i].rr});
            $display("vec %0d: mode=%0d sel=%0d valid=%0d data=%h ordy=%b -> rdy=%0d ov=%b od=%h rr=%0d",
                     i, vecs[i].m, vecs[i].sel, vecs[i].iv, vecs[i].d, vecs[i].ordy,
                     in_ready, out_valid, out_data, rr_ptr);
        end

        // Fill slots 0 and 2 with rr_ptr ending at 3, then reset between edges.
        drive(1'b1, 2'd0, 1'b1, 8'h0C, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b1, 8'h0D, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
        chk("pre_reset_out_valid", {28'd0, out_valid}, 32'h5);
        chk("pre_reset_out_data", out_data, 32'h080C0B0D);
        chk("pre_reset_rr_ptr", {30'd0, rr_ptr}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", {28'd0, out_valid}, 32'h0);
        chk("async_reset_out_data", out_data, 32'h0);
        chk("async_reset_rr_ptr", {30'd0, rr_ptr}, 32'h0);
        chk("async_reset_in_ready", {31'd0, in_ready}, 32'h1);
        $display("reset mid-op: ov=%b od=%h rr=%0d rdy=%0d", out_valid, out_data, rr_ptr, in_ready);

        // A beat offered while reset is held is lost.
        drive(1'b0, 2'd1, 1'b1, 8'h77, 4'h0);
        @(posedge clk);
        #1;
        chk("beat_in_reset_lost", {28'd0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd3, 1'b1, 8'hEE, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
        chk("first_load_out_valid", {28'd0, out_valid}, 32'h8);
        chk("first_load_out_data", out_data, 32'hEE000000);
        chk("first_load_rr_ptr", {30'd0, rr_ptr}, 32'h0);
        $display("after release: ov=%b od=%h rr=%0d", out_valid, out_data, rr_ptr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux1to4_stream.md
DEMUX1TO4_STREAM -- requirements
Module: demux1to4_stream

Interface
REQ-001 SHALL have parameter W, default 8: data width per beat.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mode, input, 1: 0 = explicit select (in_sel), 1 = auto round-robin (internal pointer).
REQ-005 SHALL have port in_sel, input, 2: destination channel in explicit mode; ignored in auto mode.
REQ-006 SHALL have port in_valid, input, 1: upstream beat present.
REQ-007 SHALL have port in_data, input, W: upstream beat payload.
REQ-008 SHALL have port in_ready, output, 1: beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port out_valid, output, 4: per-channel beat present; bit k is channel k.
REQ-010 SHALL have port out_data, output, 4*W: channel k payload in bits [k*W +: W].
REQ-011 SHALL have port out_ready, input, 4: per-channel downstream accept.
REQ-012 SHALL have port rr_ptr, output, 2: current auto-mode destination pointer.

Function
REQ-013 SHALL compute the destination dst as in_sel when mode=0 and rr_ptr when mode=1, sampled combinationally each cycle.
REQ-014 SHALL give each channel a one-entry holding slot: out_valid[k] high iff slot k is full, out_data slice k equal to the slot contents.
REQ-015 SHALL drive in_ready = ~out_valid[dst] | out_ready[dst]; in_ready has no dependency on in_valid.
REQ-016 SHALL, on an accepted beat, load in_data into slot dst and set out_valid[dst] on the next edge; latency from input to output is exactly 1 cycle.
REQ-017 SHALL clear out_valid[k] on an edge with out_valid[k] & out_ready[k], unless the same edge loads slot k.
REQ-018 SHALL, on simultaneous drain and load of the same slot, keep out_valid[k]=1 with the new payload, giving full throughput of 1 beat/cycle per channel.
REQ-019 SHALL hold slot contents and out_valid stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 SHALL leave non-destination slots unaffected by a load; every channel drains independently and simultaneously.
REQ-021 SHALL advance rr_ptr by 1 modulo 4 (3 -> 0) only on an accepted beat with mode=1; rr_ptr holds otherwise, including while mode=0.
REQ-022 SHALL stall on the pointer when the pointed slot is full and not draining: no skipping to a free channel.
REQ-023 SHALL NOT drop or duplicate beats; a change of in_sel or mode while in_valid is high and in_ready is low is a protocol violation by upstream, and the block only re-evaluates dst.

Reset
REQ-024 SHALL, on rst_n low, immediately force out_valid=4'b0000, out_data=0, and rr_ptr=2'b00, discarding held beats.
REQ-025 SHALL drive in_ready from REQ-015 during reset, with all slots empty, so in_ready reads 1 while reset is asserted; beats offered during reset are lost.
REQ-026 SHALL leave reset synchronously to clk via the release edge of rst_n, with the first load possible on the first rising edge after release.

Structure
REQ-027 SHALL place NUM_CH=4, SEL_W=2, and the mode enum (MODE_SEL=0, MODE_RR=1) in shared package demux_pkg.
REQ-028 SHALL instantiate sub-module demux_slot (parameter W; ports clk, rst_n, load, load_data, drain_ready, valid, data) four times.
REQ-029 SHALL keep the dst decode, in_ready logic, and rr_ptr counter in the top level, with no other state.

Verification
REQ-030 Explicit route: mode=0, in_sel=2, in_data=8'hA5, out_ready=4'hF -> next cycle out_valid=4'b0100 and slice 2 = 8'hA5; next cycle out_valid=0.
REQ-031 Back-pressure: mode=0, in_sel=1, out_ready[1]=0, beats 8'h11 then 8'h22 -> 8'h11 is held, in_ready=0 for the second beat; raise out_ready[1] -> 8'h11 then 8'h22 are delivered, nothing is lost.
REQ-032 Simultaneous load/drain: slot 3 full and out_ready[3]=1, new beat to channel 3 the same cycle -> out_valid[3] stays 1 and the payload updates; in_ready=1.
REQ-033 Round-robin wrap: mode=1, six accepted beats 8'h00..8'h05 -> they land on channels 0,1,2,3,0,1 and rr_ptr reads 2 afterward.
REQ-034 RR stall: mode=1, rr_ptr=1, slot 1 full, out_ready[1]=0, channels 0/2/3 empty -> in_ready=0 and rr_ptr holds at 1.
REQ-035 Reset mid-operation: slots 0 and 2 full, rr_ptr=3, then assert rst_n low asynchronously between edges -> out_valid=0, out_data=0, and rr_ptr=0 immediately, without waiting for a clock edge.
